core_fetch_buf: RTL and testbench

CORE_FETCH_BUF -- requirements
Module: core_fetch_buf

---
 rtl/core_pkg.sv | 14 +
 rtl/core_fetch_fifo.sv | 66 ++++++
 rtl/core_fetch_buf.sv | 148 ++++++++++++++
 tb/tb_core_fetch_buf.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-unit types and constants: FSM state encoding,
// instruction width and PC step.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

endpackage

// File: rtl/core_fetch_fifo.sv
// Prefetch FIFO: power-of-two ring buffer with synchronous flush.
// Push while full is accepted only when a pop happens in the same cycle.
module core_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/core_fetch_buf.sv
// Instruction prefetch buffer with redirect/drain handling.
// Optional perf counters enabled by defining CORE_FETCH_PERF_EN.
module core_fetch_buf
    import core_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready
`ifdef CORE_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_starved
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam int DW = ADDR_W + INSTR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_dout;
    logic              redir, gnt, rsp, push, pop;
    logic [ADDR_W-1:0] redir_addr;
    logic              unused_ok;

    assign unused_ok = ^{redirect_pc[1:0], fifo_full};

    always_comb begin
        redir      = redirect && (state_q != ST_IDLE);
        redir_addr = {redirect_pc[ADDR_W-1:2], 2'b00};
        imem_req   = (state_q == ST_RUN) && !redirect &&
                     (SW'(fifo_count) + SW'(outstanding_q) < SW'(DEPTH));
        imem_addr  = fetch_pc_q;
        gnt        = imem_req && imem_gnt;
        // Responses with nothing in flight are strays (e.g. from before reset)
        rsp        = imem_rvalid && (outstanding_q != '0);
        push       = rsp && (state_q == ST_RUN) && !redir;
        pop        = !fifo_empty && out_ready && !redir;
        out_valid  = !fifo_empty;
        out_pc     = fifo_empty ? '0 : fifo_dout[DW-1:INSTR_W];
        out_instr  = fifo_empty ? '0 : fifo_dout[INSTR_W-1:0];
    end

    always_comb begin
        outstanding_d = outstanding_q + CW'(gnt) - CW'(rsp);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        if (redir) begin
            fetch_pc_d = redir_addr;
            resp_pc_d  = redir_addr;
        end else begin
            if (gnt)  fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
            if (push) resp_pc_d  = resp_pc_q + ADDR_W'(PC_INC);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (redir)
                    state_d = (outstanding_d != '0) ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                if (!redir && outstanding_q == '0) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    core_fetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   ({resp_pc_q, imem_rdata}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef CORE_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_starved_q, perf_starved_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push);
        perf_starved_d = perf_starved_q +
                         32'((state_q != ST_IDLE) && fifo_empty);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetched_q <= '0;
            perf_starved_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_starved_q <= perf_starved_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_starved = perf_starved_q;
`endif

endmodule

// File: tb/tb_core_fetch_buf.sv
// Scoreboard bench for core_fetch_buf; second instance covers PC wrap
// from a high RESET_PC.
module tb_core_fetch_buf;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, start, redirect, imem_gnt, imem_rvalid, out_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, out_valid, imem_req2, out_valid2;
    logic [31:0] imem_addr, out_pc, out_instr;
    logic [31:0] imem_addr2, out_pc2, out_instr2;
`ifdef CORE_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_starved, perf_fetched2, perf_starved2;
    logic [31:0] s_pf, s_ps;
`endif

    int          checks = 0;
    int          failures = 0;
    int          ngrant;
    logic        rsp_hold, started;
    logic        s_req, s_valid;
    logic [31:0] s_pc;
    logic [63:0] exp_q[$];
    logic [63:0] expd_q[$];
    logic [63:0] obs_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] a2_q[$];

    always #5 clk = ~clk;

    core_fetch_buf dut (
        .clk(clk), .rstn(rstn), .start(start), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready)
`ifdef CORE_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_starved(perf_starved)
`endif
    );

    core_fetch_buf #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rstn(rstn), .start(start), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req2),
        .imem_addr(imem_addr2), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid2), .out_pc(out_pc2), .out_instr(out_instr2),
        .out_ready(out_ready)
`ifdef CORE_FETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_starved(perf_starved2)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    // One clock: sample at negedge, update scoreboard, then drive the
    // memory response for the following cycle.
    task automatic tick();
        @(negedge clk);
        s_req   = imem_req;
        s_valid = out_valid;
        s_pc    = out_pc;
`ifdef CORE_FETCH_PERF_EN
        s_pf = perf_fetched;
        s_ps = perf_starved;
`endif
        if (redirect && started) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            obs_q.push_back({out_pc, out_instr});
            if (exp_q.size() > 0) expd_q.push_back(exp_q.pop_front());
            else expd_q.push_back('1);
        end
        if (imem_req && imem_gnt) begin
            pend_q.push_back(imem_addr);
            exp_q.push_back({imem_addr, mem_word(imem_addr)});
            ngrant++;
        end
        if (imem_req2 && imem_gnt) a2_q.push_back(imem_addr2);
        @(posedge clk);
        #1;
        if (!rsp_hold && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        out_ready = 1'b0; rsp_hold = 1'b0; started = 1'b0; ngrant = 0;
        pend_q.delete(); exp_q.delete(); expd_q.delete();
        obs_q.delete(); a2_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        started = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got req=%b valid=%b exp 0 0", imem_req, out_valid);
        end
        checks++;
        if (imem_addr !== 32'h0 || imem_addr2 !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL reset_addr got %h/%h exp 0/fffffff8", imem_addr, imem_addr2);
        end
        checks++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_out got %h/%h exp 0/0", out_pc, out_instr);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d exp %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_stream();
        do_reset();
        imem_gnt = 1'b1;
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        do_start();
        for (int k = 1; k < 16; k++) begin
            tick();
            checks++;
            if (s_valid !== (k >= 3)) begin
                failures++;
                $display("FAIL stream_valid c%0d got %b exp %b", k, s_valid, k >= 3);
            end
        end
        checks++;
        if (obs_q.size() != 13) begin
            failures++;
            $display("FAIL stream_count got %0d exp 13", obs_q.size());
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i][63:32] !== 32'(i * 4) || obs_q[i] !== expd_q[i]) begin
                failures++;
                $display("FAIL stream_entry%0d got %h exp pc %h / %h", i, obs_q[i], i * 4, expd_q[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] want;
            want = 32'hFFFF_FFF8 + 32'(i * 4);
            checks++;
            if (a2_q.size() <= i || a2_q[i] !== want) begin
                failures++;
                $display("FAIL wrap_addr%0d got %h exp %h", i, a2_q.size() > i ? a2_q[i] : 32'hx, want);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_gnt = 1'b1;
        do_start();
        repeat (11) tick();
        checks++;
        if (ngrant != 4 || s_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall got grants=%0d req=%b exp 4 0", ngrant, s_req);
        end
        out_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (ngrant <= 4) begin
            failures++;
            $display("FAIL bp_resume got grants=%0d exp >4", ngrant);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_q.size() <= i || obs_q[i][63:32] !== 32'(i * 4) || obs_q[i] !== expd_q[i]) begin
                failures++;
                $display("FAIL bp_pop%0d got %h exp pc %h", i, obs_q.size() > i ? obs_q[i] : 64'hx, i * 4);
            end
        end
    endtask

    task automatic test_redirect();
        bit seen = 0;
        do_reset();
        imem_gnt = 1'b1;
        out_ready = 1'b1;
        rsp_hold = 1'b1;
        do_start();
        repeat (2) tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        checks++;
        if (dut.state_q !== ST_DRAIN || dut.outstanding_q !== 3'd2) begin
            failures++;
            $display("FAIL redir_drain got st=%0d outst=%0d exp %0d 2", dut.state_q, dut.outstanding_q, ST_DRAIN);
        end
        imem_gnt = 1'b1;
        tick();
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_quiet got req=%b valid=%b exp 0 0", s_req, s_valid);
        end
        rsp_hold = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (s_valid && !seen) begin
                seen = 1;
                checks++;
                if (s_pc !== 32'h100) begin
                    failures++;
                    $display("FAIL redir_first got %h exp 00000100", s_pc);
                end
            end
        end
        checks++;
        if (!seen || obs_q.size() < 3) begin
            failures++;
            $display("FAIL redir_restart got %0d entries exp >=3", obs_q.size());
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== expd_q[i] || obs_q[i][63:32] !== 32'h100 + 32'(i * 4)) begin
                failures++;
                $display("FAIL redir_entry%0d got %h exp %h", i, obs_q[i], expd_q[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        imem_gnt = 1'b1;
        do_start();
        tick();
        rsp_hold = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b1 || dut.outstanding_q !== 3'd3) begin
            failures++;
            $display("FAIL midop_pre got valid=%b outst=%0d exp 1 3", out_valid, dut.outstanding_q);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0 ||
            out_pc !== 32'h0 || out_instr !== 32'h0) begin
            failures++;
            $display("FAIL midop_rst got req=%b v=%b a=%h pc=%h i=%h exp 0", imem_req, out_valid, imem_addr, out_pc, out_instr);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        started = 1'b0;
        rsp_hold = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (dut.outstanding_q !== 3'd0 || s_valid !== 1'b0) begin
                failures++;
                $display("FAIL midop_stray c%0d got outst=%0d valid=%b exp 0 0", k, dut.outstanding_q, s_valid);
            end
        end
    endtask

`ifdef CORE_FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && obs_q.size() < 10; k++) begin
            imem_gnt = (k >= 1 && k <= 5) || (k >= 7 && k <= 11);
            start = (k == 0);
            started = 1'b1;
            tick();
        end
        start = 1'b0;
        imem_gnt = 1'b0;
        tick();
        checks++;
        if (s_pf !== 32'd10 || s_ps !== 32'd3) begin
            failures++;
            $display("FAIL perf got fetched=%0d starved=%0d exp 10 3", s_pf, s_ps);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_reset_midop();
`ifdef CORE_FETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
